// File: rtl/alu8_pkg.sv
// Shared constants for the ToyProcessor 8-bit ALU stage.
// Holds the opcode encodings and the sequencer state type.
package alu8_pkg;

  localparam int unsigned WIDTH = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [0:0] {
    StIdle,
    StMulRun
  } state_e;

endpackage

// File: rtl/nor8.sv
// 8-input NOR used as the zero detector on the ALU result bus.
module nor8 (
  input  logic [7:0] d,
  output logic       y
);

  assign y = ~|d;

endmodule

// File: rtl/alu8_seq.sv
// 8-bit ALU stage: single-cycle logic/arith ops and an 8-step shift-add multiply,
// with registered result and Z/C/N flags under a start/busy/done handshake.
module alu8_seq
  import alu8_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MUL_STEPS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             neg,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(MUL_STEPS);
  localparam logic [CntW-1:0] CntLast = CntW'(MUL_STEPS - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q, carry_q, neg_q, busy_q, done_q;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic [2*WIDTH-1:0] pp, acc_nxt;
  logic [WIDTH-1:0]   next_res;
  logic               next_c;
  logic               next_zero;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    unique case (op)
      OP_ADD: {alu_c, alu_res} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        alu_res = a - b;
        alu_c   = (a < b);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        alu_res = {a[WIDTH-2:0], 1'b0};
        alu_c   = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      OP_MUL: begin
        alu_res = '0;
        alu_c   = 1'b0;
      end
    endcase
  end

  // One partial product per step: A shifted to the current bit position of B.
  always_comb begin
    pp      = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
    acc_nxt = acc_q + pp;
  end

  // While multiplying, the bus carries the final product so the last step can load it.
  always_comb begin
    if (state_q == StMulRun) begin
      next_res = acc_nxt[WIDTH-1:0];
      next_c   = |acc_nxt[2*WIDTH-1:WIDTH];
    end else begin
      next_res = alu_res;
      next_c   = alu_c;
    end
  end

  nor8 u_nor8 (
    .d (next_res),
    .y (next_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (op == OP_MUL) begin
              a_q     <= a;
              b_q     <= b;
              acc_q   <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= StMulRun;
            end else begin
              result_q <= next_res;
              zero_q   <= next_zero;
              carry_q  <= next_c;
              neg_q    <= next_res[WIDTH-1];
              done_q   <= 1'b1;
            end
          end
        end
        StMulRun: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            result_q <= next_res;
            zero_q   <= next_zero;
            carry_q  <= next_c;
            neg_q    <= next_res[WIDTH-1];
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign carry  = carry_q;
  assign neg    = neg_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
